mem_access_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage: consumes the EX/MEM register contents (ALU result as address, forwarded Rs2 as store data, destination and control bits) and produces the registered MEM/WB payload. Memory operations go over a single-outstanding req/ack data bus with byte/half/word lane handling and a timeout. Non-memory instructions pass through with one cycle of latency. While a bus access is in flight, the upstream pipeline is frozen via `stall`.

---
 rtl/mem_access_stage_pkg.sv | 54 +++++
 rtl/mem_access_stage_lane_align.sv | 87 ++++++++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: funct3 size/sign codes,
// FSM state codes, the default bus timeout and small decode helpers.
package mem_access_stage_pkg;

    // funct3 size/sign encodings (anything else behaves as a word)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Default number of WAIT cycles before an unanswered access is aborted
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int TMO_CNT_W              = 16;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_e;

    // Map funct3 onto an access size; unknown codes fall back to a word
    function automatic access_size_e decode_size(input logic [2:0] funct3);
        access_size_e size_v;
        case (funct3)
            F3_B, F3_BU: size_v = SZ_B;
            F3_H, F3_HU: size_v = SZ_H;
            default:     size_v = SZ_W;
        endcase
        return size_v;
    endfunction

    // Zero-extending loads
    function automatic logic is_unsigned(input logic [2:0] funct3);
        return (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Natural-alignment check for a given access size
    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
        logic mis_v;
        case (size)
            SZ_B:    mis_v = 1'b0;
            SZ_H:    mis_v = addr_lo[0];
            SZ_W:    mis_v = (addr_lo != 2'b00);
            default: mis_v = 1'b0;
        endcase
        return mis_v;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// lsu_lane_align: purely combinational byte-lane handling for the
// memory-access stage. The store side replicates data into every lane and
// builds the byte strobes; the load side picks the addressed lane out of the
// returned word and sign- or zero-extends it. Address bits finer than the
// access size are ignored here (halfwords use addr[1] only, words ignore both).
module lsu_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store strobes and lane-replicated write data
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = st_data;
        case (decode_size(st_funct3))
            SZ_B: begin
                st_strb  = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_strb  = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            SZ_W: begin
                st_strb  = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Select the addressed byte and halfword of the returned word
    always_comb begin
        ld_byte_s = ld_rdata[7:0];
        case (ld_addr_lo)
            2'b00:   ld_byte_s = ld_rdata[7:0];
            2'b01:   ld_byte_s = ld_rdata[15:8];
            2'b10:   ld_byte_s = ld_rdata[23:16];
            2'b11:   ld_byte_s = ld_rdata[31:24];
            default: ld_byte_s = ld_rdata[7:0];
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = ld_rdata[31:16];
        end else begin
            ld_half_s = ld_rdata[15:0];
        end
    end

    // Extend the selected lane to a full register value
    always_comb begin
        ld_result = ld_rdata;
        case (decode_size(ld_funct3))
            SZ_B: begin
                if (is_unsigned(ld_funct3)) begin
                    ld_result = {24'h000000, ld_byte_s};
                end else begin
                    ld_result = {{24{ld_byte_s[7]}}, ld_byte_s};
                end
            end
            SZ_H: begin
                if (is_unsigned(ld_funct3)) begin
                    ld_result = {16'h0000, ld_half_s};
                end else begin
                    ld_result = {{16{ld_half_s[15]}}, ld_half_s};
                end
            end
            SZ_W:    ld_result = ld_rdata;
            default: ld_result = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Non-memory instructions pass through in one cycle. Loads/stores go out on a
// single-outstanding req/ack bus; the upstream pipeline is stalled until the
// ack (or a timeout abort) and the result lands in the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are refused without a bus request and reported via
// bus_err; when undefined they proceed as if aligned.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_result,
    output logic        bus_err
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [0:0]           state_r;
    logic [TMO_CNT_W-1:0] tmo_cnt_r;
    logic [31:0]          lat_addr_r;
    logic [2:0]           lat_funct3_r;
    logic [4:0]           lat_rd_r;
    logic                 lat_regwrite_r;

    logic                 mem_op_s;
    logic                 misalign_s;
    logic                 accept_mem_s;
    logic                 tmo_hit_s;
    logic [3:0]           st_strb_s;
    logic [31:0]          st_wdata_s;
    logic [31:0]          ld_result_s;

    lsu_lane_align u_lane_align (
        .st_funct3  (in_funct3),
        .st_addr_lo (in_addr[1:0]),
        .st_data    (in_wdata),
        .st_strb    (st_strb_s),
        .st_wdata   (st_wdata_s),
        .ld_funct3  (lat_funct3_r),
        .ld_addr_lo (lat_addr_r[1:0]),
        .ld_rdata   (bus_rdata),
        .ld_result  (ld_result_s)
    );

    // Classify the EX/MEM slot and derive the combinational stall
    always_comb begin
        mem_op_s = in_memread | in_memwrite;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_s = in_valid & mem_op_s & is_misaligned(decode_size(in_funct3), in_addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
        accept_mem_s = (state_r == ST_IDLE) & in_valid & mem_op_s & ~misalign_s;
        tmo_hit_s    = (state_r == ST_WAIT) & ~bus_ack & (tmo_cnt_r == TMO_LIMIT);
        // Gated by rst so the freeze lifts the moment reset hits
        stall        = ~rst & (accept_mem_s | (state_r == ST_WAIT));
    end

    // Access FSM, bus request registers, timeout counter and MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            tmo_cnt_r      <= {TMO_CNT_W{1'b0}};
            lat_addr_r     <= 32'h0000_0000;
            lat_funct3_r   <= 3'b000;
            lat_rd_r       <= 5'd0;
            lat_regwrite_r <= 1'b0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'h0000_0000;
            bus_wdata      <= 32'h0000_0000;
            bus_wstrb      <= 4'b0000;
            wb_valid       <= 1'b0;
            wb_rd          <= 5'd0;
            wb_regwrite    <= 1'b0;
            wb_result      <= 32'h0000_0000;
            bus_err        <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            wb_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (misalign_s) begin
                        // Refused access: report it without touching the bus
                        bus_err     <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_rd       <= in_rd;
                        wb_regwrite <= 1'b0;
                        wb_result   <= in_addr;
                    end else if (accept_mem_s) begin
                        state_r        <= ST_WAIT;
                        tmo_cnt_r      <= {TMO_CNT_W{1'b0}};
                        lat_addr_r     <= in_addr;
                        lat_funct3_r   <= in_funct3;
                        lat_rd_r       <= in_rd;
                        lat_regwrite_r <= in_regwrite;
                        bus_req        <= 1'b1;
                        bus_we         <= in_memwrite;
                        bus_addr       <= {in_addr[31:2], 2'b00};
                        if (in_memwrite) begin
                            bus_wdata <= st_wdata_s;
                            bus_wstrb <= st_strb_s;
                        end else begin
                            bus_wdata <= 32'h0000_0000;
                            bus_wstrb <= 4'b0000;
                        end
                    end else if (in_valid) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= in_rd;
                        wb_regwrite <= in_regwrite;
                        wb_result   <= in_addr;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        // Ack beats a simultaneous timeout
                        state_r  <= ST_IDLE;
                        bus_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= lat_rd_r;
                        if (bus_we) begin
                            wb_regwrite <= 1'b0;
                            wb_result   <= lat_addr_r;
                        end else begin
                            wb_regwrite <= lat_regwrite_r;
                            wb_result   <= ld_result_s;
                        end
                    end else if (tmo_hit_s) begin
                        state_r     <= ST_IDLE;
                        bus_req     <= 1'b0;
                        bus_err     <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_rd       <= lat_rd_r;
                        wb_regwrite <= 1'b0;
                        wb_result   <= lat_addr_r;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (built with a 4-cycle
// bus timeout). Inputs change on the falling edge, outputs are sampled on
// the falling edge, away from the active rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_memread;
    logic        in_memwrite;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_memread  (in_memread),
        .in_memwrite (in_memwrite),
        .in_funct3   (in_funct3),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .stall       (stall),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .wb_result   (wb_result),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        memread;
        logic        memwrite;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        regwrite;
        int          wait_n;
        logic [31:0] rdata;
        logic [31:0] exp_result;
        logic        exp_regwrite;
        logic [31:0] exp_bus_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_bus_wdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw);
        in_valid    = v;
        in_addr     = a;
        in_wdata    = d;
        in_memread  = mr;
        in_memwrite = mw;
        in_funct3   = f3;
        in_rd       = rd;
        in_regwrite = rw;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        logic  mem;
        tag = $sformatf("v%0d", idx);
        mem = v.memread | v.memwrite;
        @(negedge clk);
        drive(1'b1, v.addr, v.wdata, v.memread, v.memwrite, v.funct3, v.rd, v.regwrite);
        bus_ack = 1'b0;
        #1;
        chk({tag, "_stall_in"}, {31'h0, stall}, {31'h0, mem});
        @(negedge clk);
        if (mem) begin
            chk({tag, "_req"}, {31'h0, bus_req}, 32'h1);
            chk({tag, "_we"}, {31'h0, bus_we}, {31'h0, v.memwrite});
            chk({tag, "_baddr"}, bus_addr, v.exp_bus_addr);
            chk({tag, "_strb"}, {28'h0, bus_wstrb}, {28'h0, v.exp_strb});
            if (v.memwrite) begin
                chk({tag, "_bwdata"}, bus_wdata, v.exp_bus_wdata);
            end
            chk({tag, "_wbv0"}, {31'h0, wb_valid}, 32'h0);
            for (int w = 0; w < v.wait_n; w++) begin
                @(negedge clk);
                chk({tag, "_hold_req"}, {31'h0, bus_req}, 32'h1);
                chk({tag, "_hold_addr"}, bus_addr, v.exp_bus_addr);
                chk({tag, "_hold_strb"}, {28'h0, bus_wstrb}, {28'h0, v.exp_strb});
                chk({tag, "_hold_stall"}, {31'h0, stall}, 32'h1);
            end
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            chk({tag, "_req_off"}, {31'h0, bus_req}, 32'h0);
            chk({tag, "_err"}, {31'h0, bus_err}, 32'h0);
        end
        chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'h1);
        chk({tag, "_wbres"}, wb_result, v.exp_result);
        chk({tag, "_wbrw"}, {31'h0, wb_regwrite}, {31'h0, v.exp_regwrite});
        chk({tag, "_wbrd"}, {27'h0, wb_rd}, {27'h0, v.rd});
        in_valid = 1'b0;
        #1;
        chk({tag, "_stall_out"}, {31'h0, stall}, 32'h0);
        @(negedge clk);
        chk({tag, "_idle_wbv"}, {31'h0, wb_valid}, 32'h0);
    endtask

    // Watchdog: the bench must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          wdata         mr    mw    f3      rd     rw   wt rdata         exp_res       exp_rw bus_addr     strb     bus_wdata
        vecs[0]  = '{32'h0000_1234, 32'h0,        1'b0, 1'b0, 3'b000, 5'd5,  1'b1, 0, 32'h0,        32'h0000_1234, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[1]  = '{32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 3'b010, 5'd31, 1'b0, 0, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0,        4'b0000, 32'h0};
        vecs[2]  = '{32'h0000_0103, 32'h0,        1'b1, 1'b0, 3'b000, 5'd7,  1'b1, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b1, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[3]  = '{32'h0000_0103, 32'h0,        1'b1, 1'b0, 3'b100, 5'd8,  1'b1, 0, 32'h80FF_FFFF, 32'h0000_0080, 1'b1, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[4]  = '{32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 5'd9, 1'b1, 3, 32'h0,        32'h0000_0202, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD};
        vecs[5]  = '{32'h0000_0102, 32'h0,        1'b1, 1'b0, 3'b001, 5'd10, 1'b1, 0, 32'h8001_1234, 32'hFFFF_8001, 1'b1, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[6]  = '{32'h0000_0100, 32'h0,        1'b1, 1'b0, 3'b101, 5'd11, 1'b1, 1, 32'h8001_F234, 32'h0000_F234, 1'b1, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[7]  = '{32'h0000_0301, 32'h1234_5678, 1'b0, 1'b1, 3'b000, 5'd12, 1'b1, 0, 32'h0,       32'h0000_0301, 1'b0, 32'h0000_0300, 4'b0010, 32'h7878_7878};
        vecs[8]  = '{32'h0000_0400, 32'h0,        1'b1, 1'b0, 3'b010, 5'd13, 1'b1, 1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1, 32'h0000_0400, 4'b0000, 32'h0};
        vecs[9]  = '{32'h0000_0404, 32'h1122_3344, 1'b0, 1'b1, 3'b010, 5'd14, 1'b1, 2, 32'h0,       32'h0000_0404, 1'b0, 32'h0000_0404, 4'b1111, 32'h1122_3344};
        vecs[10] = '{32'h0000_0500, 32'h5566_7788, 1'b1, 1'b1, 3'b010, 5'd15, 1'b1, 0, 32'hFFFF_FFFF, 32'h0000_0500, 1'b0, 32'h0000_0500, 4'b1111, 32'h5566_7788};
        vecs[11] = '{32'h0000_0102, 32'h0,        1'b1, 1'b0, 3'b000, 5'd16, 1'b1, 0, 32'h0055_AA00, 32'h0000_0055, 1'b1, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[12] = '{32'h0000_0600, 32'h0,        1'b1, 1'b0, 3'b011, 5'd17, 1'b1, 0, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0600, 4'b0000, 32'h0};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        #12;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_wbv", {31'h0, wb_valid}, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
        chk("rst_wbres", wb_result, 32'h0);
        chk("rst_strb", {28'h0, bus_wstrb}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Timeout: no ack; counter runs 0..4 then aborts
        @(negedge clk);
        drive(1'b1, 32'h0000_0700, 32'h0, 1'b1, 1'b0, 3'b010, 5'd20, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("tmo_req_c%0d", c), {31'h0, bus_req}, 32'h1);
            chk($sformatf("tmo_noerr_c%0d", c), {31'h0, bus_err}, 32'h0);
        end
        @(negedge clk);
        chk("tmo_err", {31'h0, bus_err}, 32'h1);
        chk("tmo_req_off", {31'h0, bus_req}, 32'h0);
        chk("tmo_wbv", {31'h0, wb_valid}, 32'h1);
        chk("tmo_wbrw", {31'h0, wb_regwrite}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("tmo_err_pulse", {31'h0, bus_err}, 32'h0);

        // Ack exactly on the expiry cycle: normal completion
        drive(1'b1, 32'h0000_0704, 32'h0, 1'b1, 1'b0, 3'b010, 5'd21, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("exp_ack_err", {31'h0, bus_err}, 32'h0);
        chk("exp_ack_wbv", {31'h0, wb_valid}, 32'h1);
        chk("exp_ack_res", wb_result, 32'h0BAD_F00D);
        chk("exp_ack_rw", {31'h0, wb_regwrite}, 32'h1);
        chk("exp_ack_req", {31'h0, bus_req}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);

        // Misaligned word load at 0x101
        drive(1'b1, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 5'd22, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("mis_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_req", {31'h0, bus_req}, 32'h0);
        chk("mis_err", {31'h0, bus_err}, 32'h1);
        chk("mis_wbv", {31'h0, wb_valid}, 32'h1);
        chk("mis_wbrw", {31'h0, wb_regwrite}, 32'h0);
        @(negedge clk);
        chk("mis_err_pulse", {31'h0, bus_err}, 32'h0);
`else
        @(negedge clk);
        chk("mis_req", {31'h0, bus_req}, 32'h1);
        chk("mis_baddr", bus_addr, 32'h0000_0100);
        bus_ack   = 1'b1;
        bus_rdata = 32'h7654_3210;
        @(negedge clk);
        bus_ack  = 1'b0;
        in_valid = 1'b0;
        chk("mis_err", {31'h0, bus_err}, 32'h0);
        chk("mis_wbv", {31'h0, wb_valid}, 32'h1);
        chk("mis_res", wb_result, 32'h7654_3210);
        @(negedge clk);
`endif

        // Reset during WAIT drops everything at once
        drive(1'b1, 32'h0000_0800, 32'h0, 1'b1, 1'b0, 3'b010, 5'd23, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rw_req_pre", {31'h0, bus_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_req", {31'h0, bus_req}, 32'h0);
        chk("rw_stall", {31'h0, stall}, 32'h0);
        chk("rw_wbv", {31'h0, wb_valid}, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        chk("rw_wbv_after", {31'h0, wb_valid}, 32'h0);
        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
